// File: rtl/audio_pkg.sv
// Shared audio constants used by the tone generator and the I2S transmitter.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = 2 * SAMPLE_W;

  localparam int MCLK_BIT = 1;
  localparam int SCK_BIT  = 3;
  localparam int LRCK_BIT = 8;

  localparam logic [SAMPLE_W-1:0] SILENCE = 16'h0000;

  // Slot p (1..31) carries frame bit 32-p; slot 0 carries the previous LSB.
  function automatic logic [4:0] slot_bit_idx(input logic [4:0] slot);
    return 5'(6'd32 - {1'b0, slot});
  endfunction

endpackage

// File: rtl/audio_clk_div.sv
// Free-running frame counter and the registered DAC clocks derived from it.
module audio_clk_div
  import audio_pkg::*;
#(
  parameter int FRAME_BITS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [FRAME_BITS-1:0] cnt,
  output logic                  mclk,
  output logic                  sck,
  output logic                  lrck
);

  logic [FRAME_BITS-1:0] cnt_q, cnt_d;
  logic                  mclk_q, sck_q, lrck_q;

  always_comb begin
    cnt_d = cnt_q + {{(FRAME_BITS-1){1'b0}}, 1'b1};
  end

  // Clock flops load from cnt_d so they stay bit-aligned with cnt_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      mclk_q <= 1'b0;
      sck_q  <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mclk_q <= cnt_d[MCLK_BIT];
      sck_q  <= cnt_d[SCK_BIT];
      lrck_q <= cnt_d[LRCK_BIT];
    end
  end

  assign cnt  = cnt_q;
  assign mclk = mclk_q;
  assign sck  = sck_q;
  assign lrck = lrck_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: captures a stereo sample once per frame and shifts it out
// MSB first with the one-bit I2S delay.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int FRAME_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  output logic                audio_mclk,
  output logic                audio_sck,
  output logic                audio_lrck,
  output logic                audio_sdin,
  output logic                frame_start
);

  logic [FRAME_BITS-1:0] cnt, cnt_nxt;
  logic [4:0]            slot_nxt;
  logic                  capture, bit_edge;

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               lsb_q, lsb_d;
  logic               sdin_q, sdin_d;
  logic               frame_start_q, frame_start_d;

  audio_clk_div #(
    .FRAME_BITS (FRAME_BITS)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .mclk (audio_mclk),
    .sck  (audio_sck),
    .lrck (audio_lrck)
  );

  // Data is registered one edge ahead, so decisions use the next count.
  assign cnt_nxt  = cnt + {{(FRAME_BITS-1){1'b0}}, 1'b1};
  assign slot_nxt = cnt_nxt[FRAME_BITS-1 -: 5];
  assign bit_edge = (cnt_nxt[SCK_BIT:0] == '0);
  assign capture  = (cnt == '1);

  always_comb begin
    frame_d       = frame_q;
    lsb_d         = lsb_q;
    sdin_d        = sdin_q;
    frame_start_d = capture;

    if (capture) begin
      lsb_d   = frame_q[0];
      frame_d = en ? {audio_left, audio_right} : {SILENCE, SILENCE};
    end

    if (bit_edge) begin
      if (slot_nxt == 5'd0) begin
        sdin_d = lsb_d;
      end else begin
        sdin_d = frame_q[slot_bit_idx(slot_nxt)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q       <= '0;
      lsb_q         <= 1'b0;
      sdin_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_q       <= frame_d;
      lsb_q         <= lsb_d;
      sdin_q        <= sdin_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign audio_sdin  = sdin_q;
  assign frame_start = frame_start_q;

endmodule
